// File: rtl/vga_tile_controller_if.sv
// Memory-side bus of the VGA tile controller: pixel/tile address out, BGR data back
// after the controller's fixed read latency.
interface vga_tile_controller_if #(
    parameter int ADDR_W = 19,
    parameter int ROW_W  = 6,
    parameter int COL_W  = 7
);
    logic [ADDR_W-1:0] address;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  column;
    logic [23:0]       bgr_data_raw;

    // No valid/ready: the memory returns bgr_data_raw exactly PIPE clocks after address.
    modport master (output address, output row, output column, input bgr_data_raw);
    modport slave  (input address, input row, input column, output bgr_data_raw);
endinterface

// File: rtl/vga_tile_controller.sv
// VGA pixel engine: sync generation, incremental pixel/tile addressing, latency-matched
// colour output with a frame-locked test-pattern mode.
module vga_tile_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int TILE_W_LOG2 = 3,
    parameter int TILE_H_LOG2 = 3,
    parameter int ADDR_W      = 19,
    parameter int PIPE        = 2
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST_n,
    input  logic [1:0]               iMODE,
    vga_tile_controller_if.master    mem,
    output logic                     oHS,
    output logic                     oVS,
    output logic                     oBLANK_n,
    output logic                     oFRAME_START,
    output logic [7:0]               b_data,
    output logic [7:0]               g_data,
    output logic [7:0]               r_data
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCNT_W  = $clog2(H_TOTAL);
    localparam int VCNT_W  = $clog2(V_TOTAL);
    localparam int ROW_W   = $clog2(V_ACTIVE >> TILE_H_LOG2);
    localparam int COL_W   = $clog2(H_ACTIVE >> TILE_W_LOG2);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BARC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HCNT_W-1:0] H_ACT_C  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_LAST_C = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] HS_BEG_C = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END_C = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] V_ACT_C  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LAST_C = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] VS_BEG_C = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END_C = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HCNT_W-1:0] TW_MASK  = HCNT_W'((1 << TILE_W_LOG2) - 1);
    localparam logic [VCNT_W-1:0] TH_MASK  = VCNT_W'((1 << TILE_H_LOG2) - 1);
    localparam logic [BARC_W-1:0] BARC_MAX = BARC_W'(BAR_W - 1);

    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [1:0] mode;
        logic [2:0] bar;
        logic       grid;
    } side_t;

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic [BARC_W-1:0] r_bar_cnt;
    logic [2:0]        r_bar;
    logic [1:0]        r_mode;
    side_t             r_side_a;
    side_t             r_dly [PIPE];

    logic        w_h_last;
    logic        w_v_last;
    logic        w_origin;
    logic        w_active;
    logic [1:0]  w_mode;
    side_t       w_side;
    side_t       w_out;
    logic [23:0] w_bgr;

    assign w_h_last = (r_hcnt == H_LAST_C);
    assign w_v_last = (r_vcnt == V_LAST_C);
    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_active = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    // The mode is sampled at the frame origin so the whole frame uses one pattern.
    assign w_mode   = w_origin ? iMODE : r_mode;

    always_comb begin
        w_side        = '0;
        w_side.active = w_active;
        w_side.hs     = (r_hcnt >= HS_BEG_C) && (r_hcnt < HS_END_C);
        w_side.vs     = (r_vcnt >= VS_BEG_C) && (r_vcnt < VS_END_C);
        w_side.fs     = w_origin;
        w_side.mode   = w_mode;
        w_side.bar    = r_bar;
        w_side.grid   = ((r_hcnt & TW_MASK) == '0) || ((r_vcnt & TH_MASK) == '0);
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_bar_cnt   <= '0;
            r_bar       <= '0;
            r_mode      <= '0;
            r_side_a    <= '0;
            mem.address <= '0;
            mem.row     <= '0;
            mem.column  <= '0;
        end else begin
            r_mode   <= w_mode;
            r_side_a <= w_side;
            if (w_h_last) begin
                r_hcnt    <= '0;
                r_vcnt    <= w_v_last ? '0 : r_vcnt + VCNT_W'(1);
                r_bar_cnt <= '0;
                r_bar     <= '0;
            end else begin
                r_hcnt <= r_hcnt + HCNT_W'(1);
                if (r_bar_cnt == BARC_MAX) begin
                    r_bar_cnt <= '0;
                    r_bar     <= r_bar + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + BARC_W'(1);
                end
            end
            // Running index instead of vcnt*H_ACTIVE+hcnt; frozen over blanking.
            if (w_origin)
                mem.address <= '0;
            else if (w_active)
                mem.address <= mem.address + ADDR_W'(1);
            mem.row    <= ROW_W'(r_vcnt >> TILE_H_LOG2);
            mem.column <= COL_W'(r_hcnt >> TILE_W_LOG2);
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            for (int i = 0; i < PIPE; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= r_side_a;
            for (int i = 1; i < PIPE; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_out = r_dly[PIPE-1];

    always_comb begin
        w_bgr = '0;
        if (w_out.active) begin
            case (w_out.mode)
                2'd0: w_bgr = mem.bgr_data_raw;
                2'd1: w_bgr = {{8{w_out.bar[2]}}, {8{w_out.bar[1]}}, {8{w_out.bar[0]}}};
                2'd2: w_bgr = w_out.grid ? 24'hFFFFFF : mem.bgr_data_raw;
                default: w_bgr = '0;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oHS          <= ~HS_POL;
            oVS          <= ~VS_POL;
            oBLANK_n     <= 1'b0;
            oFRAME_START <= 1'b0;
            b_data       <= '0;
            g_data       <= '0;
            r_data       <= '0;
        end else begin
            oHS          <= w_out.hs ? HS_POL : ~HS_POL;
            oVS          <= w_out.vs ? VS_POL : ~VS_POL;
            oBLANK_n     <= w_out.active;
            oFRAME_START <= w_out.fs;
            {b_data, g_data, r_data} <= w_bgr;
        end
    end
endmodule

// File: tb/tb_vga_tile_controller.sv
// Directed bench for vga_tile_controller on a small 16x8 timing set with a 2-clock memory model.
module tb_vga_tile_controller;
    localparam int FRAME = 288;
    localparam int HT    = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       hs, vs, blank_n, fs;
    logic [7:0] b, g, r;
    logic [23:0] m1, m2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fmode [0:31];

    always #5 clk = ~clk;

    vga_tile_controller_if #(.ADDR_W(8), .ROW_W(2), .COL_W(3)) mem_if ();

    vga_tile_controller #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .TILE_W_LOG2(1), .TILE_H_LOG2(1), .ADDR_W(8), .PIPE(2)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iMODE(mode), .mem(mem_if),
        .oHS(hs), .oVS(vs), .oBLANK_n(blank_n), .oFRAME_START(fs),
        .b_data(b), .g_data(g), .r_data(r)
    );

    // Memory returns the address byte replicated, two clocks after the address.
    always @(posedge clk) begin
        m1 <= {3{mem_if.address}};
        m2 <= m1;
    end
    assign mem_if.bgr_data_raw = m2;

    task automatic tick();
        if (rst_n && (cyc % FRAME == 0)) fmode[(cyc / FRAME) % 32] = int'(mode);
        @(posedge clk);
        if (rst_n) cyc++;
        else cyc = 0;
        @(negedge clk);
    endtask

    // Expected values after cyc clocks since reset release.
    task automatic get_exp(output logic [7:0] e_addr, output logic [1:0] e_row,
                           output logic [2:0] e_col, output logic e_hs, output logic e_vs,
                           output logic e_blank, output logic e_fs, output logic [23:0] e_rgb);
        int p, h, v, q, f, bar;
        logic [7:0] pa;
        e_addr = 0; e_row = 0; e_col = 0;
        if (cyc > 0) begin
            p = (cyc - 1) % FRAME; h = p % HT; v = p / HT;
            if (v >= 8) e_addr = 8'd127;
            else if (h >= 16) e_addr = 8'(v * 16 + 15);
            else e_addr = 8'(v * 16 + h);
            e_row = 2'((v >> 1) & 3);
            e_col = 3'((h >> 1) & 7);
        end
        e_hs = 1; e_vs = 1; e_blank = 0; e_fs = 0; e_rgb = 0;
        if (cyc >= 4) begin
            p = cyc - 4; f = p / FRAME; q = p % FRAME; h = q % HT; v = q / HT;
            e_hs = !(h >= 18 && h < 21);
            e_vs = !(v >= 9 && v < 11);
            e_fs = (q == 0);
            e_blank = (h < 16 && v < 8);
            pa = 8'(v * 16 + h);
            bar = h / 2;
            if (e_blank) begin
                case (fmode[f % 32])
                    0: e_rgb = {pa, pa, pa};
                    1: e_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
                    2: e_rgb = ((h % 2 == 0) || (v % 2 == 0)) ? 24'hFFFFFF : {pa, pa, pa};
                    default: e_rgb = 0;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode  = 2'd0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests += 8;
            if (hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs got %b exp 1", hs); end
            if (vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs got %b exp 1", vs); end
            if (blank_n !== 1'b0) begin n_fail++; $display("FAIL reset_blank got %b exp 0", blank_n); end
            if (fs !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", fs); end
            if ({b, g, r} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h exp 0", {b, g, r}); end
            if (mem_if.address !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", mem_if.address); end
            if (mem_if.row !== 2'd0) begin n_fail++; $display("FAIL reset_row got %0d exp 0", mem_if.row); end
            if (mem_if.column !== 3'd0) begin n_fail++; $display("FAIL reset_col got %0d exp 0", mem_if.column); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        logic [7:0] ea; logic [1:0] er; logic [2:0] ec; logic eh, ev, eb, ef; logic [23:0] ergb;
        for (int k = 0; k < 6; k++) begin
            tick();
            get_exp(ea, er, ec, eh, ev, eb, ef, ergb);
            n_tests += 3;
            if (mem_if.address !== ea) begin n_fail++; $display("FAIL start_addr c=%0d got %0d exp %0d", cyc, mem_if.address, ea); end
            if (blank_n !== eb) begin n_fail++; $display("FAIL start_blank c=%0d got %b exp %b", cyc, blank_n, eb); end
            if (fs !== ef) begin n_fail++; $display("FAIL start_fs c=%0d got %b exp %b", cyc, fs, ef); end
            if (cyc == 4) begin
                n_tests++;
                if (blank_n !== 1'b1 || fs !== 1'b1) begin
                    n_fail++; $display("FAIL first_pixel got blank=%b fs=%b exp 1/1", blank_n, fs);
                end
            end
        end
    endtask

    task automatic test_free_run();
        logic [7:0] ea; logic [1:0] er; logic [2:0] ec; logic eh, ev, eb, ef; logic [23:0] ergb;
        while (cyc < FRAME + 12) begin
            tick();
            get_exp(ea, er, ec, eh, ev, eb, ef, ergb);
            n_tests += 8;
            if (mem_if.address !== ea) begin n_fail++; $display("FAIL run_addr c=%0d got %0d exp %0d", cyc, mem_if.address, ea); end
            if (mem_if.row !== er) begin n_fail++; $display("FAIL run_row c=%0d got %0d exp %0d", cyc, mem_if.row, er); end
            if (mem_if.column !== ec) begin n_fail++; $display("FAIL run_col c=%0d got %0d exp %0d", cyc, mem_if.column, ec); end
            if (hs !== eh) begin n_fail++; $display("FAIL run_hs c=%0d got %b exp %b", cyc, hs, eh); end
            if (vs !== ev) begin n_fail++; $display("FAIL run_vs c=%0d got %b exp %b", cyc, vs, ev); end
            if (blank_n !== eb) begin n_fail++; $display("FAIL run_blank c=%0d got %b exp %b", cyc, blank_n, eb); end
            if (fs !== ef) begin n_fail++; $display("FAIL run_fs c=%0d got %b exp %b", cyc, fs, ef); end
            if ({b, g, r} !== ergb) begin n_fail++; $display("FAIL run_rgb c=%0d got %h exp %h", cyc, {b, g, r}, ergb); end
        end
    endtask

    task automatic test_colour_bars();
        logic [7:0] ea; logic [1:0] er; logic [2:0] ec; logic eh, ev, eb, ef; logic [23:0] ergb;
        mode = 2'd1;
        repeat (2 * FRAME) begin
            tick();
            get_exp(ea, er, ec, eh, ev, eb, ef, ergb);
            n_tests += 2;
            if (blank_n !== eb) begin n_fail++; $display("FAIL bars_blank c=%0d got %b exp %b", cyc, blank_n, eb); end
            if ({b, g, r} !== ergb) begin n_fail++; $display("FAIL bars_rgb c=%0d got %h exp %h", cyc, {b, g, r}, ergb); end
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] ea; logic [1:0] er; logic [2:0] ec; logic eh, ev, eb, ef; logic [23:0] ergb;
        mode = 2'd0;
        while (cyc % FRAME != 4 * HT) tick();
        mode = 2'd3;
        repeat (2 * FRAME) begin
            tick();
            get_exp(ea, er, ec, eh, ev, eb, ef, ergb);
            n_tests += 3;
            if ({b, g, r} !== ergb) begin n_fail++; $display("FAIL switch_rgb c=%0d got %h exp %h", cyc, {b, g, r}, ergb); end
            if (hs !== eh) begin n_fail++; $display("FAIL switch_hs c=%0d got %b exp %b", cyc, hs, eh); end
            if (vs !== ev) begin n_fail++; $display("FAIL switch_vs c=%0d got %b exp %b", cyc, vs, ev); end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] ea; logic [1:0] er; logic [2:0] ec; logic eh, ev, eb, ef; logic [23:0] ergb;
        mode = 2'd2;
        while (cyc % FRAME != 3 * HT + 10) tick();
        rst_n = 1'b0;
        tick();
        n_tests += 7;
        if (hs !== 1'b1) begin n_fail++; $display("FAIL mid_hs got %b exp 1", hs); end
        if (vs !== 1'b1) begin n_fail++; $display("FAIL mid_vs got %b exp 1", vs); end
        if (blank_n !== 1'b0) begin n_fail++; $display("FAIL mid_blank got %b exp 0", blank_n); end
        if (fs !== 1'b0) begin n_fail++; $display("FAIL mid_fs got %b exp 0", fs); end
        if ({b, g, r} !== 24'h0) begin n_fail++; $display("FAIL mid_rgb got %h exp 0", {b, g, r}); end
        if (mem_if.address !== 8'd0) begin n_fail++; $display("FAIL mid_addr got %0d exp 0", mem_if.address); end
        if ({mem_if.row, mem_if.column} !== 5'd0) begin n_fail++; $display("FAIL mid_tile got %h exp 0", {mem_if.row, mem_if.column}); end
        rst_n = 1'b1;
        repeat (FRAME + 12) begin
            tick();
            get_exp(ea, er, ec, eh, ev, eb, ef, ergb);
            n_tests += 5;
            if (mem_if.address !== ea) begin n_fail++; $display("FAIL grid_addr c=%0d got %0d exp %0d", cyc, mem_if.address, ea); end
            if (blank_n !== eb) begin n_fail++; $display("FAIL grid_blank c=%0d got %b exp %b", cyc, blank_n, eb); end
            if (fs !== ef) begin n_fail++; $display("FAIL grid_fs c=%0d got %b exp %b", cyc, fs, ef); end
            if (hs !== eh) begin n_fail++; $display("FAIL grid_hs c=%0d got %b exp %b", cyc, hs, eh); end
            if ({b, g, r} !== ergb) begin n_fail++; $display("FAIL grid_rgb c=%0d got %h exp %h", cyc, {b, g, r}, ergb); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) fmode[i] = 0;
        rst_n = 1'b0;
        mode  = 2'd0;
        test_reset();
        test_startup();
        test_free_run();
        test_colour_bars();
        test_mode_switch();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
